// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU ports, the arbiter and the unified memory.
// The slave view belongs to the arbiter; the master view drives requests and memory responses.
interface mem_arbiter_if;
  // instruction fetch port
  logic        i_req_i;
  logic [31:0] i_addr_i;
  logic [31:0] o_data_i;
  logic        o_valid_i;
  // load/store port
  logic        i_rd_d;
  logic [3:0]  i_we_d;
  logic [31:0] i_addr_d;
  logic [31:0] i_wdata_d;
  logic [31:0] o_data_d;
  logic        o_valid_d;
  logic        o_timeout;
  // memory side
  logic [31:0] o_mem_addr;
  logic        o_mem_rd;
  logic [3:0]  o_mem_we;
  logic [31:0] o_mem_wdata;
  logic [31:0] i_mem_rdata;
  logic        i_mem_ack;

  modport slave (
    input  i_req_i, i_addr_i, i_rd_d, i_we_d, i_addr_d, i_wdata_d, i_mem_rdata, i_mem_ack,
    output o_data_i, o_valid_i, o_data_d, o_valid_d, o_timeout,
           o_mem_addr, o_mem_rd, o_mem_we, o_mem_wdata
  );

  modport master (
    output i_req_i, i_addr_i, i_rd_d, i_we_d, i_addr_d, i_wdata_d, i_mem_rdata, i_mem_ack,
    input  o_data_i, o_valid_i, o_data_d, o_valid_d, o_timeout,
           o_mem_addr, o_mem_rd, o_mem_we, o_mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port 32-bit memory between the
// instruction-fetch port and the load/store port, one transaction at a time,
// with an optional watchdog that aborts transactions the memory never acks.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          i_clk,
  input  logic          i_rst,
  mem_arbiter_if.slave  bus
);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LIMIT = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  state_t           r_state,     w_state_nxt;
  logic             r_last_d,    w_last_d_nxt;   // 1: last grant went to the data port
  logic [CNT_W-1:0] r_cnt,       w_cnt_nxt;
  logic [31:0]      r_mem_addr,  w_mem_addr_nxt;
  logic             r_mem_rd,    w_mem_rd_nxt;
  logic [3:0]       r_mem_we,    w_mem_we_nxt;
  logic [31:0]      r_mem_wdata, w_mem_wdata_nxt;
  logic [31:0]      r_data_i,    w_data_i_nxt;
  logic [31:0]      r_data_d,    w_data_d_nxt;
  logic             r_valid_i,   w_valid_i_nxt;
  logic             r_valid_d,   w_valid_d_nxt;
  logic             r_timeout,   w_timeout_nxt;

  logic w_req_d;
  logic w_expire;
  logic w_done;
  logic w_grant_i;
  logic w_grant_d;

  assign w_req_d  = bus.i_rd_d | (|bus.i_we_d);
  assign w_expire = (TIMEOUT != 0) && (r_cnt == LIMIT);
  assign w_done   = bus.i_mem_ack | w_expire;

  // Next-state, arbitration, completion and watchdog decisions
  always_comb begin
    w_state_nxt     = r_state;
    w_last_d_nxt    = r_last_d;
    w_cnt_nxt       = r_cnt + CNT_W'(1);
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_rd_nxt    = r_mem_rd;
    w_mem_we_nxt    = r_mem_we;
    w_mem_wdata_nxt = r_mem_wdata;
    w_data_i_nxt    = r_data_i;
    w_data_d_nxt    = r_data_d;
    w_valid_i_nxt   = 1'b0;
    w_valid_d_nxt   = 1'b0;
    w_timeout_nxt   = 1'b0;
    w_grant_i       = 1'b0;
    w_grant_d       = 1'b0;

    case (r_state)
      IDLE: begin
        w_cnt_nxt = r_cnt;
        // a lone requester wins; on a tie the port not served last wins
        if (bus.i_req_i && (!w_req_d || r_last_d)) begin
          w_grant_i = 1'b1;
        end else if (w_req_d) begin
          w_grant_d = 1'b1;
        end
      end
      GNT_I: begin
        if (w_done) begin
          w_valid_i_nxt = 1'b1;
          w_timeout_nxt = ~bus.i_mem_ack;
          w_data_i_nxt  = bus.i_mem_ack ? bus.i_mem_rdata : 32'h0;
          // only the other port may follow back-to-back
          if (w_req_d) begin
            w_grant_d = 1'b1;
          end else begin
            w_state_nxt  = IDLE;
            w_mem_rd_nxt = 1'b0;
            w_mem_we_nxt = 4'b0;
          end
        end
      end
      GNT_D: begin
        if (w_done) begin
          w_valid_d_nxt = 1'b1;
          w_timeout_nxt = ~bus.i_mem_ack;
          // writes leave the read-result register untouched
          if (r_mem_we == 4'b0) begin
            w_data_d_nxt = bus.i_mem_ack ? bus.i_mem_rdata : 32'h0;
          end
          if (bus.i_req_i) begin
            w_grant_i = 1'b1;
          end else begin
            w_state_nxt  = IDLE;
            w_mem_rd_nxt = 1'b0;
            w_mem_we_nxt = 4'b0;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    if (w_grant_i) begin
      w_state_nxt     = GNT_I;
      w_last_d_nxt    = 1'b0;
      w_cnt_nxt       = '0;
      w_mem_addr_nxt  = bus.i_addr_i;
      w_mem_rd_nxt    = 1'b1;
      w_mem_we_nxt    = 4'b0;
      w_mem_wdata_nxt = 32'h0;
    end
    if (w_grant_d) begin
      w_state_nxt     = GNT_D;
      w_last_d_nxt    = 1'b1;
      w_cnt_nxt       = '0;
      w_mem_addr_nxt  = bus.i_addr_d;
      w_mem_rd_nxt    = ~(|bus.i_we_d);
      w_mem_we_nxt    = bus.i_we_d;
      w_mem_wdata_nxt = bus.i_wdata_d;
    end
  end

  // State and output registers; reset abandons any transaction at once
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_last_d    <= 1'b1;
      r_cnt       <= '0;
      r_mem_addr  <= 32'h0;
      r_mem_rd    <= 1'b0;
      r_mem_we    <= 4'b0;
      r_mem_wdata <= 32'h0;
      r_data_i    <= 32'h0;
      r_data_d    <= 32'h0;
      r_valid_i   <= 1'b0;
      r_valid_d   <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_last_d    <= w_last_d_nxt;
      r_cnt       <= w_cnt_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_rd    <= w_mem_rd_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_data_i    <= w_data_i_nxt;
      r_data_d    <= w_data_d_nxt;
      r_valid_i   <= w_valid_i_nxt;
      r_valid_d   <= w_valid_d_nxt;
      r_timeout   <= w_timeout_nxt;
    end
  end

  assign bus.o_mem_addr  = r_mem_addr;
  assign bus.o_mem_rd    = r_mem_rd;
  assign bus.o_mem_we    = r_mem_we;
  assign bus.o_mem_wdata = r_mem_wdata;
  assign bus.o_data_i    = r_data_i;
  assign bus.o_data_d    = r_data_d;
  assign bus.o_valid_i   = r_valid_i;
  assign bus.o_valid_d   = r_valid_d;
  assign bus.o_timeout   = r_timeout;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: arbitration order, latency, write hold,
// watchdog abort, ack/timeout tie and asynchronous reset.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          n_chk = 0;
  int          n_pass = 0;
  logic [3:0]  mem_wait;
  logic        mem_mute;
  int unsigned wcnt;
  logic        cmd;

  mem_arbiter_if u_if();

  mem_arbiter #(.TIMEOUT(4)) u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (u_if)
  );

  always #5 clk = ~clk;

  // Memory model: acks after mem_wait cycles of a held command; mute never acks.
  // Read data: 0x13 at 0x100, otherwise the inverted address.
  assign cmd = u_if.o_mem_rd | (|u_if.o_mem_we);
  always_comb begin
    u_if.i_mem_ack   = cmd && !mem_mute && (wcnt >= 32'(mem_wait));
    u_if.i_mem_rdata = (u_if.o_mem_addr == 32'h100) ? 32'h13 : ~u_if.o_mem_addr;
  end
  always @(posedge clk or posedge rst) begin
    if (rst) wcnt <= 0;
    else if (!cmd || u_if.i_mem_ack) wcnt <= 0;
    else wcnt <= wcnt + 32'd1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #60000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench time limit");
  end

  initial begin
    u_if.i_req_i   = 1'b1;
    u_if.i_addr_i  = 32'h40;
    u_if.i_rd_d    = 1'b1;
    u_if.i_we_d    = 4'b0;
    u_if.i_addr_d  = 32'h200;
    u_if.i_wdata_d = 32'h0;
    mem_wait       = 4'd0;
    mem_mute       = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // reset state
    chk("rst_mem_rd",   32'(u_if.o_mem_rd),  32'd0);
    chk("rst_mem_we",   32'(u_if.o_mem_we),  32'd0);
    chk("rst_mem_addr", u_if.o_mem_addr,     32'd0);
    chk("rst_valid_i",  32'(u_if.o_valid_i), 32'd0);
    chk("rst_valid_d",  32'(u_if.o_valid_d), 32'd0);
    chk("rst_timeout",  32'(u_if.o_timeout), 32'd0);
    chk("rst_data_i",   u_if.o_data_i,       32'd0);
    chk("rst_data_d",   u_if.o_data_d,       32'd0);

    // both request from reset: I first, then alternating with no idle cycle
    tick();
    chk("alt_g1_addr", u_if.o_mem_addr,     32'h40);
    chk("alt_g1_rd",   32'(u_if.o_mem_rd),  32'd1);
    for (int k = 2; k <= 5; k++) begin
      tick();
      chk("alt_valid_i", 32'(u_if.o_valid_i), (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("alt_valid_d", 32'(u_if.o_valid_d), (k % 2 == 0) ? 32'd0 : 32'd1);
      chk("alt_addr",    u_if.o_mem_addr,     (k % 2 == 0) ? 32'h200 : 32'h40);
      chk("alt_rd",      32'(u_if.o_mem_rd),  32'd1);
    end
    chk("alt_data_i", u_if.o_data_i, 32'hFFFF_FFBF);
    chk("alt_data_d", u_if.o_data_d, 32'hFFFF_FDFF);
    // drop both mid-fetch: the fetch still completes
    u_if.i_req_i = 1'b0;
    u_if.i_rd_d  = 1'b0;
    tick();
    chk("drop_valid_i", 32'(u_if.o_valid_i), 32'd1);
    chk("drop_mem_rd",  32'(u_if.o_mem_rd),  32'd0);
    tick();
    chk("drop_quiet_i", 32'(u_if.o_valid_i), 32'd0);

    // single fetch, zero-wait memory
    u_if.i_req_i  = 1'b1;
    u_if.i_addr_i = 32'h100;
    tick();
    chk("f_mem_rd",   32'(u_if.o_mem_rd),  32'd1);
    chk("f_mem_addr", u_if.o_mem_addr,     32'h100);
    chk("f_valid_e1", 32'(u_if.o_valid_i), 32'd0);
    tick();
    chk("f_valid_i",  32'(u_if.o_valid_i), 32'd1);
    chk("f_data_i",   u_if.o_data_i,       32'h13);
    chk("f_timeout",  32'(u_if.o_timeout), 32'd0);
    u_if.i_req_i = 1'b0;
    tick();
    chk("f_valid_off", 32'(u_if.o_valid_i), 32'd0);
    chk("f_rd_off",    32'(u_if.o_mem_rd),  32'd0);

    // write with 3 wait cycles (ack lands on the last watchdog cycle)
    mem_wait       = 4'd3;
    u_if.i_we_d    = 4'b0011;
    u_if.i_addr_d  = 32'h2000;
    u_if.i_wdata_d = 32'hDEAD_BEEF;
    tick();
    chk("w_addr",  u_if.o_mem_addr,  32'h2000);
    chk("w_wdata", u_if.o_mem_wdata, 32'hDEAD_BEEF);
    for (int k = 2; k <= 4; k++) begin
      tick();
      chk("w_we_hold",  32'(u_if.o_mem_we),  32'h3);
      chk("w_rd_hold",  32'(u_if.o_mem_rd),  32'd0);
      chk("w_no_valid", 32'(u_if.o_valid_d), 32'd0);
    end
    tick();
    chk("w_valid_d", 32'(u_if.o_valid_d), 32'd1);
    chk("w_timeout", 32'(u_if.o_timeout), 32'd0);
    chk("w_data_d",  u_if.o_data_d,       32'hFFFF_FDFF);
    u_if.i_we_d = 4'b0;
    tick();
    chk("w_valid_off", 32'(u_if.o_valid_d), 32'd0);
    chk("w_we_off",    32'(u_if.o_mem_we),  32'd0);

    // read where ack coincides with the watchdog limit
    u_if.i_rd_d   = 1'b1;
    u_if.i_addr_d = 32'h300;
    tick();
    chk("r_rd", 32'(u_if.o_mem_rd), 32'd1);
    repeat (3) tick();
    chk("r_no_valid", 32'(u_if.o_valid_d), 32'd0);
    tick();
    chk("r_valid_d", 32'(u_if.o_valid_d), 32'd1);
    chk("r_timeout", 32'(u_if.o_timeout), 32'd0);
    chk("r_data_d",  u_if.o_data_d,       32'hFFFF_FCFF);
    u_if.i_rd_d = 1'b0;
    tick();

    // memory never acks a data read: abort, fetch granted on the same edge
    mem_mute      = 1'b1;
    u_if.i_rd_d   = 1'b1;
    u_if.i_addr_d = 32'h400;
    tick();
    chk("to_addr", u_if.o_mem_addr, 32'h400);
    u_if.i_req_i  = 1'b1;
    u_if.i_addr_i = 32'h80;
    for (int k = 2; k <= 4; k++) begin
      tick();
      chk("to_no_valid", 32'(u_if.o_valid_d), 32'd0);
      chk("to_addr_hold", u_if.o_mem_addr,    32'h400);
    end
    tick();
    chk("to_valid_d", 32'(u_if.o_valid_d), 32'd1);
    chk("to_timeout", 32'(u_if.o_timeout), 32'd1);
    chk("to_data_d",  u_if.o_data_d,       32'd0);
    chk("to_b2b_addr", u_if.o_mem_addr,    32'h80);
    chk("to_b2b_rd",  32'(u_if.o_mem_rd),  32'd1);
    mem_mute    = 1'b0;
    mem_wait    = 4'd0;
    u_if.i_rd_d = 1'b0;
    tick();
    chk("to_f_valid_i", 32'(u_if.o_valid_i), 32'd1);
    chk("to_f_data_i",  u_if.o_data_i,       32'hFFFF_FF7F);
    chk("to_f_timeout", 32'(u_if.o_timeout), 32'd0);
    u_if.i_req_i = 1'b0;
    tick();
    chk("to_idle_rd", 32'(u_if.o_mem_rd), 32'd0);

    // asynchronous reset during a 5-wait fetch
    mem_wait      = 4'd5;
    u_if.i_req_i  = 1'b1;
    u_if.i_addr_i = 32'h100;
    tick();
    tick();
    chk("ar_rd_before", 32'(u_if.o_mem_rd), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    chk("ar_mem_rd",   32'(u_if.o_mem_rd),  32'd0);
    chk("ar_mem_addr", u_if.o_mem_addr,     32'd0);
    chk("ar_data_i",   u_if.o_data_i,       32'd0);
    chk("ar_valid_i",  32'(u_if.o_valid_i), 32'd0);
    u_if.i_req_i = 1'b0;
    tick();
    tick();
    rst      = 1'b0;
    mem_wait = 4'd0;
    u_if.i_req_i = 1'b1;
    tick();
    chk("ar_new_rd", 32'(u_if.o_mem_rd), 32'd1);
    tick();
    chk("ar_new_valid_i", 32'(u_if.o_valid_i), 32'd1);
    chk("ar_new_data_i",  u_if.o_data_i,       32'h13);
    u_if.i_req_i = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
